player_bag: RTL and testbench
=============================

Name: player_bag

Overview:
- Per-player bag: the consuming end of the money-collection interface.
- Money spawners emit a 1-frame 2-bit collect value (0 = none, 1..3 = bundle value). player_bag sums these values into the bag and back-pressures the spawners through Full.
- Banks the bag into Score one unit at a time while the player stands at the vault.
- Drops the whole bag on a vehicle hit. Raises Win at the winning score.
- One instance per player; sits between the money spawners / collision logic and the HUD / game-state controller.

Parameters:
- NUM_SPAWNS, 4: number of money spawners feeding this bag (1..8).
- BAG_CAP, 6: maximum bag contents in value units (1..15).
- DEPOSIT_FRAMES, 15: frames per unit transferred bag -> score (1..1023).
- STUN_FRAMES, 120: frames collection is locked out after a hit (1..1023).
- WIN_SCORE, 20: score at which Win asserts (1..255).

Ports:
- FrameClk  in   1  frame-rate clock; all state updates on its rising edge.
- ResetN  in   1  asynchronous, active-low reset.
- Enable  in   1  game running; low = synchronous clear to reset values.
- Collect  in   2*NUM_SPAWNS  packed per-spawner collect values, spawner i at [2i+1:2i].
- AtVault  in   1  player hitbox overlaps own vault.
- Hit  in   1  player hit by vehicle this frame.
- Full  out  1  bag cannot accept money; fed back to every spawner.
- Bag  out  4  current bag contents.
- Score  out  8  banked score.
- Depositing  out  1  state == DEPOSIT.
- Stunned  out  1  state == STUN.
- DropPulse  out  1  one-frame pulse when a non-empty bag is lost.
- Win  out  1  sticky win flag.

Behaviour:
- Reset (ResetN low, async) and Enable low (sync) give identical values:
  - state = COLLECT, Bag = 0, Score = 0, timer = 0.
  - Win = 0, DropPulse = 0, Depositing = 0, Stunned = 0.
- Full is a function of registers only: Full = (state != COLLECT) || (Bag >= BAG_CAP).
  - It must never depend combinationally on Collect: spawner Collect already depends on Full, so doing so creates a loop.
- Collect sum: zero-extended sum of all NUM_SPAWNS fields, 5 bits wide. Each spawner holds Collect for exactly one frame, so sample every frame.
- COLLECT state, in priority order:
  1. Hit: Bag <= 0, DropPulse = (Bag != 0), timer <= 0, go to STUN. Collect is ignored that frame.
  2. AtVault && Bag != 0: go to DEPOSIT, timer <= 0. Collect is still added this frame.
  3. Otherwise Bag <= min(Bag + sum, BAG_CAP); any excess is discarded.
- DEPOSIT state, in priority order:
  1. Hit: same as COLLECT (drop, go to STUN).
  2. !AtVault: go to COLLECT with the partial bag kept and timer cleared.
  3. timer == DEPOSIT_FRAMES-1:
     - Bag <= Bag-1, Score <= Score+1 (saturate at 255), timer <= 0.
     - If the new Score >= WIN_SCORE: go to WON.
     - Else if the new Bag == 0: go to COLLECT.
  4. Otherwise timer+1.
  - Collect is ignored in DEPOSIT (Full is high).
- STUN state: Collect, AtVault and Hit are ignored. When timer == STUN_FRAMES-1, go to COLLECT with timer <= 0; otherwise timer+1.
- WON state: Win = 1; all inputs except Enable/ResetN are ignored; Bag and Score frozen. Left only by reset or Enable low.
- Latency:
  - A collect value appears in Bag, and Full updates, one frame after Collect.
  - The first deposited unit lands DEPOSIT_FRAMES frames after DEPOSIT is entered.
- Timer is 10 bits wide, shared by DEPOSIT and STUN, and cleared on every state change.
- Hit and AtVault together in COLLECT: Hit wins.
- Bag full and AtVault: deposit proceeds normally.
- Reset mid-DEPOSIT: the partial transfer is lost; no score is credited for the partial frame count.

Decomposition:
- Shared game_pkg holds:
  - typedef enum logic [1:0] bag_state_t {COLLECT, DEPOSIT, STUN, WON};
  - the collect-value width constant (2);
  - the common frame-count timer width (10).
- One sub-module, frame_timer:
  - 10-bit counter with sync clear, enable and terminal-count compare.
  - Used for the DEPOSIT/STUN timing; reusable by spawners.

Test Plan:
1. Defaults: Collect spawner0=2 for 1 frame, then spawner2=1 for 1 frame -> Bag 2 then 3; Full stays 0.
2. Saturation: Bag=5, spawners 0 and 1 both =2 in the same frame -> Bag=6 (BAG_CAP) next frame, Full=1; a further Collect=1 leaves Bag at 6.
3. Deposit: Bag=3, AtVault held -> Depositing next frame; Score +1 every 15 frames (1, 2, 3); Bag reaches 0 after 45 frames, then state COLLECT.
4. Partial deposit and hit: Bag=4, AtVault for 20 frames then released -> Score=1, Bag=3. Then Hit -> Bag=0, DropPulse high 1 frame, Stunned and Full high for 120 frames; Collect=2 during stun is ignored.
5. Win: Score=19, Bag=2, AtVault -> Score=20 after 15 frames; Win=1 and stays 1 with Bag=1 frozen despite Hit and Collect; Enable low for 1 frame -> all cleared.
6. Async reset: drop ResetN mid-STUN, between clock edges -> all outputs reset immediately; after release, Collect=1 gives Bag=1.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and widths for the money/bag logic
package game_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DEPOSIT = 2'd1,
        STUN    = 2'd2,
        WON     = 2'd3
    } bag_state_t;

    localparam int COLLECT_W = 2;
    localparam int TIMER_W   = 10;
    localparam int BAG_W     = 4;
    localparam int SCORE_W   = 8;

endpackage

// File: rtl/player_bag_if.sv
// rtl/player_bag_if.sv - money-collection / bag status bundle between spawners, collision and HUD
interface player_bag_if
    import game_pkg::*;
#(
    parameter int NUM_SPAWNS = 4
);
    logic [COLLECT_W*NUM_SPAWNS-1:0] Collect;
    logic                            AtVault;
    logic                            Hit;
    logic                            Full;
    logic [BAG_W-1:0]                Bag;
    logic [SCORE_W-1:0]              Score;
    logic                            Depositing;
    logic                            Stunned;
    logic                            DropPulse;
    logic                            Win;

    modport master (
        output Collect, AtVault, Hit,
        input  Full, Bag, Score, Depositing, Stunned, DropPulse, Win
    );

    modport slave (
        input  Collect, AtVault, Hit,
        output Full, Bag, Score, Depositing, Stunned, DropPulse, Win
    );
endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - frame counter with sync clear, count enable and terminal-count compare
module frame_timer
    import game_pkg::*;
(
    input  logic               FrameClk,
    input  logic               ResetN,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] last,
    output logic               done
);
    logic [TIMER_W-1:0] count;

    always_ff @(posedge FrameClk or negedge ResetN) begin
        if (!ResetN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == last);
endmodule

// File: rtl/player_bag.sv
// rtl/player_bag.sv - per-player money bag: collects spawner value, banks it at the vault, drops it on a hit
module player_bag
    import game_pkg::*;
#(
    parameter int NUM_SPAWNS     = 4,
    parameter int BAG_CAP        = 6,
    parameter int DEPOSIT_FRAMES = 15,
    parameter int STUN_FRAMES    = 120,
    parameter int WIN_SCORE      = 20
) (
    input  logic         FrameClk,
    input  logic         ResetN,
    input  logic         Enable,
    player_bag_if.slave  bus
);
    localparam logic [BAG_W-1:0]   CAP_V     = BAG_W'(BAG_CAP);
    localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
    localparam logic [TIMER_W-1:0] DEP_LAST  = TIMER_W'(DEPOSIT_FRAMES - 1);
    localparam logic [TIMER_W-1:0] STUN_LAST = TIMER_W'(STUN_FRAMES - 1);

    bag_state_t         state;
    logic [BAG_W-1:0]   bag;
    logic [SCORE_W-1:0] score;
    logic               drop_pulse;
    logic               win;

    logic [4:0]         sum;
    logic [5:0]         bag_sum;
    logic [BAG_W-1:0]   bag_add;
    logic [SCORE_W-1:0] score_inc;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_done;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_SPAWNS; i++) begin
            sum = sum + 5'(bus.Collect[COLLECT_W*i +: COLLECT_W]);
        end
    end

    // Excess value beyond the bag capacity is simply lost.
    assign bag_sum   = {2'b00, bag} + {1'b0, sum};
    assign bag_add   = (bag_sum >= 6'(CAP_V)) ? CAP_V : bag_sum[BAG_W-1:0];
    assign score_inc = (score == '1) ? score : score + 1'b1;

    // The timer only runs while it is actually timing; any state change clears it.
    always_comb begin
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        if (Enable) begin
            case (state)
                DEPOSIT: if (!bus.Hit && bus.AtVault && !tmr_done) begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
                STUN: if (!tmr_done) begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    frame_timer u_timer (
        .FrameClk (FrameClk),
        .ResetN   (ResetN),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .last     ((state == STUN) ? STUN_LAST : DEP_LAST),
        .done     (tmr_done)
    );

    always_ff @(posedge FrameClk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= COLLECT;
            bag        <= '0;
            score      <= '0;
            drop_pulse <= 1'b0;
            win        <= 1'b0;
        end else if (!Enable) begin
            state      <= COLLECT;
            bag        <= '0;
            score      <= '0;
            drop_pulse <= 1'b0;
            win        <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                COLLECT: begin
                    if (bus.Hit) begin
                        bag        <= '0;
                        drop_pulse <= (bag != '0);
                        state      <= STUN;
                    end else begin
                        bag <= bag_add;
                        if (bus.AtVault && bag != '0) begin
                            state <= DEPOSIT;
                        end
                    end
                end
                DEPOSIT: begin
                    if (bus.Hit) begin
                        bag        <= '0;
                        drop_pulse <= (bag != '0);
                        state      <= STUN;
                    end else if (!bus.AtVault) begin
                        state <= COLLECT;
                    end else if (tmr_done) begin
                        bag   <= bag - 1'b1;
                        score <= score_inc;
                        if (score_inc >= WIN_V) begin
                            state <= WON;
                            win   <= 1'b1;
                        end else if (bag == BAG_W'(1)) begin
                            state <= COLLECT;
                        end
                    end
                end
                STUN: begin
                    if (tmr_done) begin
                        state <= COLLECT;
                    end
                end
                WON: begin
                    win <= 1'b1;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Full must stay register-only: spawner Collect is itself a function of Full.
    assign bus.Full       = (state != COLLECT) || (bag >= CAP_V);
    assign bus.Bag        = bag;
    assign bus.Score      = score;
    assign bus.Depositing = (state == DEPOSIT);
    assign bus.Stunned    = (state == STUN);
    assign bus.DropPulse  = drop_pulse;
    assign bus.Win        = win;
endmodule

// File: tb/tb_player_bag.sv
// tb/tb_player_bag.sv - scoreboard bench for player_bag against a behavioural bag/score model
module tb_player_bag;
    localparam int NS  = 4;
    localparam int CAP = 6;
    localparam int DF  = 15;
    localparam int SF  = 120;
    localparam int WS  = 20;

    localparam int M_COLLECT = 0;
    localparam int M_DEPOSIT = 1;
    localparam int M_STUN    = 2;
    localparam int M_WON     = 3;

    logic FrameClk = 1'b0;
    logic ResetN   = 1'b0;
    logic Enable   = 1'b0;

    player_bag_if #(.NUM_SPAWNS(NS)) bus ();

    player_bag #(
        .NUM_SPAWNS     (NS),
        .BAG_CAP        (CAP),
        .DEPOSIT_FRAMES (DF),
        .STUN_FRAMES    (SF),
        .WIN_SCORE      (WS)
    ) dut (
        .FrameClk (FrameClk),
        .ResetN   (ResetN),
        .Enable   (Enable),
        .bus      (bus.slave)
    );

    always #5 FrameClk = ~FrameClk;

    typedef struct {
        int bag;
        int score;
        int full;
        int dep;
        int stun;
        int drop;
        int win;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int m_mode, m_bag, m_score, m_frames, m_drop;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.bag   = m_bag;
        e.score = m_score;
        e.full  = (m_mode != M_COLLECT || m_bag >= CAP) ? 1 : 0;
        e.dep   = (m_mode == M_DEPOSIT) ? 1 : 0;
        e.stun  = (m_mode == M_STUN) ? 1 : 0;
        e.drop  = m_drop;
        e.win   = (m_mode == M_WON) ? 1 : 0;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = M_COLLECT; m_bag = 0; m_score = 0; m_frames = 0; m_drop = 0;
    endtask

    task automatic lose_bag();
        m_drop   = (m_bag != 0) ? 1 : 0;
        m_bag    = 0;
        m_mode   = M_STUN;
        m_frames = 0;
    endtask

    // m_frames counts frames already spent in the current DEPOSIT/STUN phase.
    task automatic model_step(input bit en, input logic [7:0] col, input bit atv, input bit hit);
        int total;
        int prev_bag;
        logic [7:0] c;
        c = col;
        total = 0;
        for (int i = 0; i < NS; i++) total += int'(c[2*i +: 2]);
        m_drop = 0;
        if (!en) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_COLLECT: begin
                if (hit) lose_bag();
                else begin
                    prev_bag = m_bag;
                    m_bag = (m_bag + total > CAP) ? CAP : m_bag + total;
                    if (atv && prev_bag != 0) begin m_mode = M_DEPOSIT; m_frames = 0; end
                end
            end
            M_DEPOSIT: begin
                if (hit) lose_bag();
                else if (!atv) begin m_mode = M_COLLECT; m_frames = 0; end
                else if (m_frames + 1 == DF) begin
                    m_bag--;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_frames = 0;
                    if (m_score >= WS) m_mode = M_WON;
                    else if (m_bag == 0) m_mode = M_COLLECT;
                end else m_frames++;
            end
            M_STUN: begin
                if (m_frames + 1 == SF) begin m_mode = M_COLLECT; m_frames = 0; end
                else m_frames++;
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic [7:0] col, input bit atv = 0, input bit hit = 0,
                        input bit en = 1, input bit rst = 1);
        @(negedge FrameClk);
        #1;
        ResetN      = rst;
        Enable      = en;
        bus.Collect = col;
        bus.AtVault = atv;
        bus.Hit     = hit;
        if (!rst) model_reset();
        else model_step(en, col, atv, hit);
        sbq.push_back(snap());
    endtask

    task automatic hold(input int n, input logic [7:0] col, input bit atv, input bit hit = 0);
        for (int i = 0; i < n; i++) step(col, atv, hit);
    endtask

    always @(negedge FrameClk) begin
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("bag",        int'(bus.Bag),        mon_e.bag);
            chk("score",      int'(bus.Score),      mon_e.score);
            chk("full",       int'(bus.Full),       mon_e.full);
            chk("depositing", int'(bus.Depositing), mon_e.dep);
            chk("stunned",    int'(bus.Stunned),    mon_e.stun);
            chk("drop_pulse", int'(bus.DropPulse),  mon_e.drop);
            chk("win",        int'(bus.Win),        mon_e.win);
        end
    end

    initial begin
        bit atv_r;
        bus.Collect = '0;
        bus.AtVault = 1'b0;
        bus.Hit     = 1'b0;
        model_reset();

        step(8'h00, 0, 0, 1, 0);
        step(8'h00);

        // Two single-spawner bundles, then saturation at the cap.
        step(8'h02); step(8'h10); step(8'h00);
        step(8'h02); step(8'h0A); step(8'h01); step(8'h00);

        // Full three-unit deposit.
        step(8'h00, 0, 0, 0);
        step(8'h03);
        hold(48, 8'h00, 1);
        step(8'h00);

        // Partial deposit, then a hit and a full stun with collect ignored.
        step(8'h00, 0, 0, 0);
        step(8'h03); step(8'h01);
        hold(20, 8'h00, 1);
        step(8'h00, 1, 1);
        hold(SF + 3, 8'h02, 0);
        step(8'h01);

        // Bank 19, then win on the 20th unit and stay frozen.
        step(8'h00, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            step(8'h03); step(8'h03);
            hold(6 * DF + 3, 8'h00, 1);
            step(8'h00);
        end
        step(8'h01);
        hold(DF + 2, 8'h00, 1);
        step(8'h00);
        step(8'h02);
        hold(DF + 1, 8'h00, 1);
        step(8'hFF, 1, 1); step(8'h03, 0, 1); step(8'h05);
        step(8'h00, 0, 0, 0);
        step(8'h00);

        // Asynchronous reset in the middle of a stun, between clock edges.
        step(8'h02);
        step(8'h00, 0, 1);
        hold(10, 8'h00, 0);
        @(negedge FrameClk);
        #3;
        chk("stun_before_reset", int'(bus.Stunned), (m_mode == M_STUN) ? 1 : 0);
        ResetN = 1'b0;
        #1;
        model_reset();
        chk("async_bag",     int'(bus.Bag),     m_bag);
        chk("async_stunned", int'(bus.Stunned), 0);
        chk("async_full",    int'(bus.Full),    0);
        chk("async_score",   int'(bus.Score),   m_score);
        sbq.push_back(snap());
        step(8'h01);
        step(8'h00);

        // Randomised play: vault visits in runs, occasional hits and disables.
        atv_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) atv_r = ~atv_r;
            step(8'($urandom_range(0, 255)), atv_r,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 399) != 0);
        end

        step(8'h00); step(8'h00);
        @(negedge FrameClk);
        #2;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
